// File: rtl/bus_arbiter.sv
// Two-master (M0 fixed priority, M1 starvation-guarded) to one-slave single-beat arbiter.
// Latency: grant in IDLE at T, write ack at T+1, read ack at T+1+RD_LAT; one transaction per two cycles max.
// Backpressure: one transaction outstanding; masters hold req until gnt, are ignored from gnt until their ack.
module bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 0,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              s_we_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic              owner_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Value loaded into the latency counter on leaving ISSUE; unused when RD_LAT is 0.
    localparam logic [2:0] LAT_LOAD  = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] s_addr_q,  s_addr_d;
    logic              s_we_q,    s_we_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              owner_q,   owner_d;
    logic [3:0]        burst_q,   burst_d;
    logic [2:0]        lat_q,     lat_d;

    logic sel_m1;
    logic grant;
    logic ack;
    logic rd_ack;

    // Winner selection and grant: only in IDLE, and never while reset is asserted,
    // since a request may already be pending when reset lands.
    always_comb begin
        sel_m1 = m1_req_i & (~m0_req_i | (burst_q == BURST_MAX));
        grant  = rstn_i & (state_q == ST_IDLE) & (m0_req_i | m1_req_i);
    end

    // Completion decode: s_we_q is only ever 1 in ISSUE, so it also identifies writes there;
    // WAIT is only reachable by reads.
    always_comb begin
        ack    = ((state_q == ST_ISSUE) && (s_we_q || (RD_LAT == 0))) ||
                 ((state_q == ST_WAIT) && (lat_q == 3'd0));
        rd_ack = ack & ~s_we_q;
    end

    // Master-facing outputs: only the owner sees ack/rdata, the other side reads zero.
    always_comb begin
        m0_gnt_o   = grant & ~sel_m1;
        m1_gnt_o   = grant &  sel_m1;
        m0_ack_o   = ack & ~owner_q;
        m1_ack_o   = ack &  owner_q;
        m0_rdata_o = (rd_ack && !owner_q) ? s_rdata_i : '0;
        m1_rdata_o = (rd_ack &&  owner_q) ? s_rdata_i : '0;
        s_addr_o   = s_addr_q;
        s_we_o     = s_we_q;
        s_wdata_o  = s_wdata_q;
        owner_o    = owner_q;
        busy_o     = (state_q != ST_IDLE);
    end

    // Next-state logic for the FSM, slave registers, burst guard and latency counter.
    always_comb begin
        state_d   = state_q;
        s_addr_d  = s_addr_q;
        s_we_d    = 1'b0;
        s_wdata_d = s_wdata_q;
        owner_d   = owner_q;
        burst_d   = burst_q;
        lat_d     = lat_q;

        unique case (state_q)
            ST_IDLE: begin
                // Starvation guard bookkeeping only moves in IDLE.
                if (!m1_req_i) begin
                    burst_d = 4'd0;
                end
                if (grant) begin
                    state_d = ST_ISSUE;
                    owner_d = sel_m1;
                    if (sel_m1) begin
                        s_addr_d  = m1_addr_i;
                        s_we_d    = m1_we_i;
                        s_wdata_d = m1_wdata_i;
                        burst_d   = 4'd0;
                    end else begin
                        s_addr_d  = m0_addr_i;
                        s_we_d    = m0_we_i;
                        s_wdata_d = m0_wdata_i;
                        if (m1_req_i && (burst_q != BURST_MAX)) begin
                            burst_d = burst_q + 4'd1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (s_we_q || (RD_LAT == 0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_LOAD;
                end
            end
            ST_WAIT: begin
                if (lat_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction without an ack.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            s_addr_q  <= '0;
            s_we_q    <= 1'b0;
            s_wdata_q <= '0;
            owner_q   <= 1'b0;
            burst_q   <= 4'd0;
            lat_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            s_addr_q  <= s_addr_d;
            s_we_q    <= s_we_d;
            s_wdata_q <= s_wdata_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            lat_q     <= lat_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two instances (RD_LAT=2 and RD_LAT=3) share stimulus.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Each scenario task checks its own expectations inline.
module tb_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i, s_rdata_i;

    logic        m0_gnt, m0_ack, m1_gnt, m1_ack, s_we, owner, busy;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_gnt3, m0_ack3, m1_gnt3, m1_ack3, s_we3, owner3, busy3;
    logic [31:0] m0_rdata3, m1_rdata3, s_addr3, s_wdata3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .MAX_BURST(4)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
        .s_addr_o(s_addr), .s_we_o(s_we), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata_i),
        .owner_o(owner), .busy_o(busy)
    );

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_BURST(4)) u_dut3 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt3), .m0_ack_o(m0_ack3), .m0_rdata_o(m0_rdata3),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt3), .m1_ack_o(m1_ack3), .m1_rdata_o(m1_rdata3),
        .s_addr_o(s_addr3), .s_we_o(s_we3), .s_wdata_o(s_wdata3), .s_rdata_i(s_rdata_i),
        .owner_o(owner3), .busy_o(busy3)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        @(negedge clk_i);
    endtask

    // Outputs held at zero while reset is asserted, even with both requests pending.
    task automatic test_reset;
        rstn_i = 1'b0;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        #2;
        n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt got %b exp 0", m0_gnt); end
        n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m1_gnt got %b exp 0", m1_gnt); end
        n_checks++; if ({m0_ack, m1_ack, s_we, owner, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 00000", {m0_ack, m1_ack, s_we, owner, busy}); end
        n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL reset_s_addr got %h exp 0", s_addr); end
        n_checks++; if (s_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_s_wdata got %h exp 0", s_wdata); end
        n_checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {m0_rdata, m1_rdata}); end
        repeat (2) tick();
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        settle();
        rstn_i = 1'b1;
        tick();
    endtask

    // Single M0 write: gnt at T, slave strobe and ack at T+1, idle at T+2.
    task automatic test_write;
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h8000_0010; m0_wdata_i = 32'hDEAD_BEEF;
        settle();
        n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt got m0=%b m1=%b exp m0=1 m1=0", m0_gnt, m1_gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_T got %b exp 0", busy); end
        tick();
        m0_req_i = 1'b0;
        settle();
        n_checks++; if (s_we !== 1'b1) begin n_fail++; $display("FAIL wr_s_we got %b exp 1", s_we); end
        n_checks++; if (s_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL wr_s_addr got %h exp 80000010", s_addr); end
        n_checks++; if (s_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_s_wdata got %h exp deadbeef", s_wdata); end
        n_checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack got m0=%b m1=%b exp m0=1 m1=0", m0_ack, m1_ack); end
        n_checks++; if (busy !== 1'b1 || owner !== 1'b0) begin n_fail++; $display("FAIL wr_busy_owner got %b%b exp 10", busy, owner); end
        tick();
        settle();
        n_checks++; if ({busy, m0_ack, s_we} !== 3'b000) begin n_fail++; $display("FAIL wr_idle got %b exp 000", {busy, m0_ack, s_we}); end
        tick();
    endtask

    // M1 read on the RD_LAT=2 instance: ack only at T+3 carrying slave data of that cycle.
    task automatic test_read_latency;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h0000_0004; m1_wdata_i = 32'h0; s_rdata_i = 32'hFFFF_0000;
        settle();
        n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_gnt got m0=%b m1=%b exp m0=0 m1=1", m0_gnt, m1_gnt); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            m1_req_i = 1'b0;
            s_rdata_i = (i == 3) ? 32'h1234_5678 : (32'hFFFF_0000 | i);
            settle();
            n_checks++; if (m1_ack !== (i == 3)) begin n_fail++; $display("FAIL rd_ack_T%0d got %b exp %b", i, m1_ack, (i == 3)); end
            n_checks++; if (m1_rdata !== ((i == 3) ? 32'h1234_5678 : 32'h0)) begin n_fail++; $display("FAIL rd_data_T%0d got %h", i, m1_rdata); end
            n_checks++; if (s_we !== 1'b0 || m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_side_T%0d s_we=%b m0_ack=%b m0_rdata=%h exp zeros", i, s_we, m0_ack, m0_rdata); end
            n_checks++; if (owner !== 1'b1) begin n_fail++; $display("FAIL rd_owner_T%0d got %b exp 1", i, owner); end
            if (i == 2) begin
                n_checks++; if (s_addr !== 32'h4) begin n_fail++; $display("FAIL rd_s_addr got %h exp 4", s_addr); end
            end
        end
        tick();
        s_rdata_i = 32'h0;
    endtask

    // Continuous contention: four M0 grants then one M1 grant, at least 2 cycles apart.
    task automatic test_arbitration;
        logic [9:0] exp_order;
        int k;
        int last;
        exp_order = 10'b10000_10000;
        k = 0; last = -100;
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h10; m0_wdata_i = 32'h1;
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h20; m1_wdata_i = 32'h2;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (m0_gnt || m1_gnt) begin
                n_checks++; if (m0_gnt && m1_gnt) begin n_fail++; $display("FAIL arb_both_gnt cycle %0d got both exp one", c); end
                n_checks++; if (c - last < 2) begin n_fail++; $display("FAIL arb_spacing cycle %0d got gap %0d exp >=2", c, c - last); end
                if (k < 10) begin
                    n_checks++; if (m1_gnt !== exp_order[k]) begin n_fail++; $display("FAIL arb_order grant %0d got m1=%b exp m1=%b", k, m1_gnt, exp_order[k]); end
                end
                last = c;
                k++;
            end
            tick();
        end
        n_checks++; if (k != 10) begin n_fail++; $display("FAIL arb_count got %0d grants exp 10", k); end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();
    endtask

    // M1 withdraws just before its guarded grant: counter clears, M0 keeps winning.
    task automatic test_m1_drop;
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h30; m0_wdata_i = 32'h3;
        m1_we_i = 1'b1; m1_addr_i = 32'h40; m1_wdata_i = 32'h4;
        for (int c = 0; c <= 10; c++) begin
            m1_req_i = !(c == 7 || c == 8);
            settle();
            n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_m1_gnt cycle %0d got 1 exp 0", c); end
            n_checks++; if (m0_gnt !== (c % 2 == 0)) begin n_fail++; $display("FAIL drop_m0_gnt cycle %0d got %b exp %b", c, m0_gnt, (c % 2 == 0)); end
            tick();
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();
    endtask

    // Asynchronous reset in the WAIT state of a read: everything drops at once, no late ack.
    task automatic test_async_reset;
        rstn_i = 1'b0;
        tick();
        settle();
        rstn_i = 1'b1;
        tick();
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h20; m0_wdata_i = 32'h0;
        settle();
        n_checks++; if (m0_gnt3 !== 1'b1 || m0_gnt !== 1'b1) begin n_fail++; $display("FAIL ar_first_gnt got %b%b exp 11", m0_gnt3, m0_gnt); end
        tick();
        m0_req_i = 1'b0;
        tick();
        #2;
        n_checks++; if (busy3 !== 1'b1) begin n_fail++; $display("FAIL ar_in_wait got busy %b exp 1", busy3); end
        rstn_i = 1'b0;
        m0_req_i = 1'b1;
        #1;
        n_checks++; if ({busy3, s_we3, m0_gnt3, m1_gnt3, m0_ack3, m1_ack3} !== 6'b0) begin n_fail++; $display("FAIL ar_ctrl got %b exp 000000", {busy3, s_we3, m0_gnt3, m1_gnt3, m0_ack3, m1_ack3}); end
        n_checks++; if ({s_addr3, s_wdata3, m0_rdata3, m1_rdata3} !== 128'h0 || owner3 !== 1'b0) begin n_fail++; $display("FAIL ar_data got addr=%h owner=%b exp 0", s_addr3, owner3); end
        n_checks++; if (busy !== 1'b0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL ar_lat2 got busy=%b gnt=%b exp 0", busy, m0_gnt); end
        repeat (2) tick();
        m0_req_i = 1'b0;
        settle();
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            n_checks++; if (m0_ack3 !== 1'b0 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL ar_no_ack cycle %0d got %b%b exp 00", i, m0_ack3, m0_ack); end
        end
        tick();
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h44; m0_wdata_i = 32'h77;
        settle();
        n_checks++; if (m0_gnt3 !== 1'b1) begin n_fail++; $display("FAIL ar_regrant got %b exp 1", m0_gnt3); end
        tick();
        m0_req_i = 1'b0;
        settle();
        n_checks++; if (m0_ack3 !== 1'b1 || s_addr3 !== 32'h44 || s_we3 !== 1'b1) begin n_fail++; $display("FAIL ar_regrant_ack got ack=%b addr=%h we=%b exp 1 44 1", m0_ack3, s_addr3, s_we3); end
        tick();
    endtask

    // Inputs changing after gnt must not disturb the latched slave registers.
    task automatic test_addr_change;
        int acks;
        acks = 0;
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h100; m0_wdata_i = 32'hA5A5_A5A5;
        settle();
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL ac_gnt got %b exp 1", m0_gnt); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            m0_req_i = 1'b0; m0_addr_i = 32'h200; m0_wdata_i = 32'h5A5A_5A5A;
            settle();
            if (m0_ack) acks++;
            n_checks++; if (s_addr !== 32'h100 || s_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ac_latched_T%0d got %h/%h exp 100/a5a5a5a5", i, s_addr, s_wdata); end
        end
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL ac_ack_count got %0d exp 1", acks); end
        tick();
    endtask

    initial begin
        rstn_i = 1'b0;
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0;
        s_rdata_i = 32'h0;
        test_reset();
        test_write();
        test_read_latency();
        test_arbitration();
        test_m1_drop();
        test_async_reset();
        test_addr_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
